periph_bus_bridge: RTL
======================

// Module: periph_bus_bridge
// PURPOSE
//  Sequential N-slot successor to the combinational data-side bridge: decodes the CPU data-memory
//  request against parametrised address windows, drives exactly one slave, waits on per-slave
//  ready (wait states), stalls the CPU meanwhile, and flags unmapped/timed-out accesses as bus errors.
//  Sits between the pipeline MEM stage and DM / timers / interrupt-response / future peripherals.
// PARAMETERS
//  N_SLV     4                         number of slave slots (1..16)
//  SLV_BASE  {N_SLV{32'h0}}            packed N_SLV*32; slot i base = SLV_BASE[32*i+:32]
//  SLV_MASK  {N_SLV{32'hFFFF_FFFF}}    packed N_SLV*32; slot i hit when (addr & MASK_i) == BASE_i
//  TIMEOUT   16                        max ACCESS cycles before bus error; 0 = no timeout
// PORTS
//  clk                  in   1         system clock, all state on posedge
//  reset                in   1         synchronous, active-high
//  kernel_m_data_req    in   1         CPU issues access this cycle (sampled in IDLE only)
//  kernel_m_data_addr   in   32        byte address
//  kernel_m_data_wdata  in   32        write data (already lane-aligned)
//  kernel_m_data_byteen in   4         !=0 write with lane enables; ==0 read
//  kernel_m_data_rdata  out  32        read data, valid when kernel_m_data_done
//  kernel_m_data_stall  out  1         CPU must freeze MEM stage and earlier
//  kernel_m_data_done   out  1         1-cycle pulse: access complete
//  kernel_m_data_err    out  1         1-cycle pulse with done: unmapped or timeout
//  slv_sel              out  N_SLV     one-hot slave select, only in ACCESS
//  slv_addr             out  32        latched address
//  slv_wdata            out  32        latched write data
//  slv_byteen           out  4         latched byteen (0 for reads)
//  slv_rdata            in   N_SLV*32  slot i read data at [32*i+:32]
//  slv_ready            in   N_SLV     slot i completes access in current cycle
// BEHAVIOUR
//  - Reset: state IDLE; slv_sel=0, slv_addr/wdata/byteen=0, rdata=0, done=0, err=0, counter=0.
//    Reset in any state aborts transaction in that cycle; no done/err pulse is emitted.
//  - Decode: combinational on kernel addr; overlapping windows -> lowest index wins.
//  - States IDLE, ACCESS, DONE, ERR (one-cycle DONE/ERR).
//    IDLE: req & hit   -> latch addr/wdata/byteen/idx, counter=0, ACCESS.
//          req & miss  -> ERR. !req -> IDLE.
//    ACCESS: slv_sel[idx]=1; slv_* driven from latches only (stable whole access).
//          slv_ready[idx]=1 -> capture slv_rdata[idx] (reads only; writes leave rdata unchanged), DONE.
//          else counter++; TIMEOUT!=0 & counter==TIMEOUT-1 -> ERR.
//          Ready from unselected slots ignored.
//    DONE: done=1, err=0 -> IDLE.  ERR: done=1, err=1, rdata unchanged -> IDLE.
//  - stall = (IDLE & req) | ACCESS; low in DONE/ERR so CPU consumes result that cycle.
//  - req in DONE/ERR ignored; back-to-back access accepted in following IDLE cycle.
//  - Latency: zero-wait slave: req at T, ACCESS T+1 with ready, done at T+2; each wait state +1.
//    Unmapped: done+err at T+1. Timeout: err pulse TIMEOUT+1 cycles after req.
//  - kernel_m_data_rdata holds last captured value between accesses.
//  - Timed-out write may have partially landed; still reported as err (CPU raises AdES/AdEL).
//  - Counter width $clog2(TIMEOUT+1), saturates; never wraps into false completion.
// TESTING
//  1 DM slot0 base 0 mask FFFF_C000, ready tied 1: read 0x0000_1000 with slv_rdata0=DEADBEEF ->
//    stall at T,T+1; done T+2, rdata=DEADBEEF, err=0.
//  2 Slot1 base 7F00 mask FFFF_FFF0, ready after 3 waits: write 0x7F04 byteen F wdata 12345678 ->
//    slv_sel=0010 for 4 cycles, slv_wdata stable, done 5 cycles after req, rdata unchanged.
//  3 Unmapped addr 0x0000_FF00 (no hit) -> done+err at T+1, slv_sel never asserted.
//  4 TIMEOUT=16, slot2 ready stuck 0 -> sel held 16 cycles, then done+err; next req accepted after.
//  5 reset asserted in 2nd ACCESS cycle -> next cycle IDLE, sel=0, stall=0, no done pulse.
//  6 Overlap slots 0 and 3 on same window, both ready -> only slv_sel[0], rdata from slot 0;
//    back-to-back reads complete on consecutive done pulses 3 cycles apart.

Source files
------------

// File: rtl/periph_bus_bridge.sv
// ============================================================================
// periph_bus_bridge : sequential N-slot data-side bridge with wait states,
//                     CPU stall, and unmapped/timeout bus-error reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module periph_bus_bridge #(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {N_SLV{32'h0}},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {N_SLV{32'hFFFF_FFFF}},
  parameter int                  TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kernel_m_data_req,
  input  logic [31:0]         kernel_m_data_addr,
  input  logic [31:0]         kernel_m_data_wdata,
  input  logic [3:0]          kernel_m_data_byteen,
  output logic [31:0]         kernel_m_data_rdata,
  output logic                kernel_m_data_stall,
  output logic                kernel_m_data_done,
  output logic                kernel_m_data_err,
  output logic [N_SLV-1:0]    slv_sel,
  output logic [31:0]         slv_addr,
  output logic [31:0]         slv_wdata,
  output logic [3:0]          slv_byteen,
  input  logic [N_SLV*32-1:0] slv_rdata,
  input  logic [N_SLV-1:0]    slv_ready
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_SLV-1:0]   hit_vec;
  logic               hit_any;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic [3:0]         byteen_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               latch_en, cnt_inc, cap_en, ready_sel;

  for (genvar i = 0; i < N_SLV; i++) begin : g_hit
    assign hit_vec[i] = (kernel_m_data_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
  end

  // Scan from the top so the lowest matching window is the one that sticks.
  always_comb begin
    hit_any = |hit_vec;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  assign ready_sel = slv_ready[idx_q];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    cnt_inc  = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kernel_m_data_req) begin
          if (hit_any) begin
            latch_en = 1'b1;
            state_d  = S_ACCESS;
          end else begin
            state_d  = S_ERR;
          end
        end
      end
      S_ACCESS: begin
        if (ready_sel) begin
          cap_en  = (byteen_q == 4'd0);
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (latch_en) begin
        idx_q    <= hit_idx;
        addr_q   <= kernel_m_data_addr;
        wdata_q  <= kernel_m_data_wdata;
        byteen_q <= kernel_m_data_byteen;
        cnt_q    <= '0;
      end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cap_en) rdata_q <= slv_rdata[32*idx_q +: 32];
    end
  end

  always_comb begin
    slv_sel = '0;
    if (state_q == S_ACCESS) slv_sel[idx_q] = 1'b1;
  end

  assign slv_addr             = addr_q;
  assign slv_wdata            = wdata_q;
  assign slv_byteen           = byteen_q;
  assign kernel_m_data_rdata  = rdata_q;
  assign kernel_m_data_done   = (state_q == S_DONE) || (state_q == S_ERR);
  assign kernel_m_data_err    = (state_q == S_ERR);
  // Low in DONE/ERR so the CPU consumes the result in that cycle.
  assign kernel_m_data_stall  = ((state_q == S_IDLE) && kernel_m_data_req) || (state_q == S_ACCESS);

endmodule

`default_nettype wire
